register_file_mp: RTL and testbench

Parametrised multi-read-port register file for the datapath. It is the next generation of the two-read/one-write 32x32 register file. Adds:
- configurable width, depth and read-port count
- byte-enabled writes
- optional write-to-read bypass
- a sequential clear engine, so large arrays are swept one entry per cycle instead of being cleared in one cycle

Sits between decode (read addresses) and writeback (write port). Entry 0 is hardwired to zero.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_clear_fsm.sv | 36 +++
 rtl/register_file_mp.sv | 60 ++++++
 tb/tb_register_file_mp.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state type, sizing limits and byte-merge helper for the register file
package regfile_pkg;
  typedef enum logic {IDLE, CLEAR} state_e;
  localparam int DATA_W_MAX = 512;
  localparam int BE_W = DATA_W_MAX / 8;
  // Callers zero-extend narrower words into this width and truncate the result.
  function automatic logic [DATA_W_MAX-1:0] be_merge(input logic [DATA_W_MAX-1:0] old_w,
                                                     input logic [DATA_W_MAX-1:0] new_w,
                                                     input logic [BE_W-1:0] be);
    logic [DATA_W_MAX-1:0] r;
    r = old_w;
    for (int i = 0; i < BE_W; i++) r[i*8 +: 8] = be[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
    return r;
  endfunction
endpackage

// File: rtl/regfile_clear_fsm.sv
// regfile_clear_fsm: sweeps entries 1..DEPTH-1 to zero, one per cycle, after reset or clear_req
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic last;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= ADDR_W'(1);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end
  always_comb begin
    last    = ptr_q == {ADDR_W{1'b1}};
    state_d = (state_q == IDLE) ? (clear_req ? CLEAR : IDLE) : (last ? IDLE : CLEAR);
    ptr_d   = (state_q == IDLE) ? ADDR_W'(1) : ptr_q + ADDR_W'(1);
  end
  always_comb begin
    busy     = state_q == CLEAR;
    clr_we   = state_q == CLEAR;
    clr_addr = ptr_q;
  end
endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: multi-read-port register file with byte-enabled writes, optional bypass and sweep clear
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/8-1:0]      wr_be,
  input  logic                     clear_req,
  output logic                     busy
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic clr_we, wr_ok;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] wr_word_d;
  regfile_clear_fsm #(.ADDR_W(ADDR_W)) u_clear_fsm (
    .clk      (clk),
    .rst      (rst),
    .clear_req(clear_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );
  always_comb begin
    wr_ok     = !busy && wr_en && wr_addr != '0;
    wr_word_d = DATA_W'(be_merge(DATA_W_MAX'(mem_q[wr_addr]), DATA_W_MAX'(wr_data), BE_W'(wr_be)));
  end
  // Entry 0 is never written; its reads are forced to zero in each port.
  always_ff @(posedge clk) begin
    if (clr_we) mem_q[clr_addr] <= '0;
    else if (wr_ok) mem_q[wr_addr] <= wr_word_d;
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] rd_q, rd_d, old_w;
    assign a = rd_addr[k*ADDR_W +: ADDR_W];
    always_comb begin
      old_w = (a == '0) ? '0 : mem_q[a];
      rd_d  = !rd_en[k] ? rd_q :
              busy ? '0 :
              ((BYPASS != 0) && wr_ok && wr_addr == a) ? wr_word_d : old_w;
    end
    always_ff @(posedge clk) begin
      if (rst) rd_q <= '0;
      else rd_q <= rd_d;
    end
    assign rd_data[k*DATA_W +: DATA_W] = rd_q;
  end
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed bench checking a bypass/2-port and a no-bypass/4-port instance against a model
module tb_register_file_mp;
  logic clk = 1'b0;
  logic rst, wr_en, clear_req;
  logic [4:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0] wr_be;
  logic [1:0] rd_en_a;
  logic [9:0] rd_addr_a;
  logic [63:0] rd_data_a;
  logic busy_a;
  logic [3:0] rd_en_b;
  logic [19:0] rd_addr_b;
  logic [127:0] rd_data_b;
  logic busy_b;
  int checks = 0;
  int errors = 0;
  int n;
  logic [31:0] m [32];
  logic [31:0] exp_a [2];
  logic [31:0] exp_b [4];
  int clr_left;
  bit started = 1'b0;

  always #5 clk = ~clk;

  register_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .clear_req(clear_req), .busy(busy_a)
  );
  register_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .clear_req(clear_req), .busy(busy_b)
  );

  function automatic logic [31:0] mix(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] be);
    logic [31:0] mask;
    for (int i = 0; i < 4; i++) mask[i*8 +: 8] = {8{be[i]}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  function automatic logic [31:0] peek(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'h0;
    if (byp && wr_en && wr_addr == a) return mix(m[a], wr_data, wr_be);
    return m[a];
  endfunction

  // Model: clr_left counts remaining sweep cycles; memory is forced to zero throughout a clear.
  always @(posedge clk) begin
    if (rst) begin
      started  <= 1'b1;
      clr_left <= 31;
      for (int k = 0; k < 2; k++) exp_a[k] <= 32'h0;
      for (int k = 0; k < 4; k++) exp_b[k] <= 32'h0;
    end else if (clr_left > 0) begin
      clr_left <= clr_left - 1;
      for (int i = 0; i < 32; i++) m[i] <= 32'h0;
      for (int k = 0; k < 2; k++) if (rd_en_a[k]) exp_a[k] <= 32'h0;
      for (int k = 0; k < 4; k++) if (rd_en_b[k]) exp_b[k] <= 32'h0;
    end else begin
      if (clear_req) clr_left <= 31;
      if (wr_en && wr_addr != 5'd0) m[wr_addr] <= mix(m[wr_addr], wr_data, wr_be);
      for (int k = 0; k < 2; k++) if (rd_en_a[k]) exp_a[k] <= peek(rd_addr_a[k*5 +: 5], 1'b1);
      for (int k = 0; k < 4; k++) if (rd_en_b[k]) exp_b[k] <= peek(rd_addr_b[k*5 +: 5], 1'b0);
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp("model_busy_a", 32'(busy_a), 32'(clr_left != 0));
      cmp("model_busy_b", 32'(busy_b), 32'(clr_left != 0));
      for (int k = 0; k < 2; k++) cmp($sformatf("model_rd_a%0d", k), rd_data_a[k*32 +: 32], exp_a[k]);
      for (int k = 0; k < 4; k++) cmp($sformatf("model_rd_b%0d", k), rd_data_b[k*32 +: 32], exp_b[k]);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic quiet();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0; clear_req = 1'b0;
    rd_en_a = '0; rd_en_b = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    step();
    quiet();
  endtask

  task automatic rd_all(input logic [4:0] a);
    rd_en_a = 2'b11; rd_addr_a = {2{a}};
    rd_en_b = 4'hF; rd_addr_b = {4{a}};
    step();
    quiet();
  endtask

  task automatic count_busy();
    n = 0;
    while (busy_a && n < 40) begin
      n++;
      step();
    end
    cmp("busy_len", 32'(n), 32'd31);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rd_addr_a = '0; rd_addr_b = '0;
    quiet();
    step();
    rst = 1'b0;
    cmp("rst_busy", 32'(busy_a), 32'd1);
    cmp("rst_rd_a", rd_data_a[31:0], 32'h0);
    count_busy();
    for (int a = 0; a < 32; a++) begin
      rd_all(5'(a));
      cmp("post_clr_a0", rd_data_a[31:0], 32'h0);
      cmp("post_clr_a1", rd_data_a[63:32], 32'h0);
    end
    wr(5'd1, 32'hF0F0F0F0, 4'hF);
    rd_en_a = 2'b01; rd_addr_a = {5'd0, 5'd1};
    step();
    quiet();
    cmp("rd_r1", rd_data_a[31:0], 32'hF0F0F0F0);
    rd_addr_a = {5'd0, 5'd5};
    step();
    cmp("hold_r1", rd_data_a[31:0], 32'hF0F0F0F0);
    wr(5'd1, 32'h12345678, 4'b0101);
    rd_all(5'd1);
    cmp("be_merge", rd_data_a[31:0], 32'hF034F078);
    wr(5'd0, 32'h0F0F0F0F, 4'hF);
    rd_all(5'd0);
    cmp("r0_zero", rd_data_a[31:0], 32'h0);
    wr(5'd1, 32'hFFFFFFFF, 4'h0);
    rd_all(5'd1);
    cmp("be_zero_noop", rd_data_b[31:0], 32'hF034F078);
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'hAAAAAAAA; wr_be = 4'hF;
    rd_en_a = 2'b10; rd_addr_a = {5'd31, 5'd0};
    rd_en_b = 4'b0010; rd_addr_b = {5'd0, 5'd0, 5'd31, 5'd0};
    step();
    quiet();
    cmp("bypass_on", rd_data_a[63:32], 32'hAAAAAAAA);
    cmp("bypass_off_old", rd_data_b[63:32], 32'h0);
    rd_en_b = 4'b0010;
    step();
    quiet();
    cmp("bypass_off_next", rd_data_b[63:32], 32'hAAAAAAAA);
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'h000000BB; wr_be = 4'b0001;
    rd_en_a = 2'b01; rd_addr_a = {5'd0, 5'd1};
    step();
    quiet();
    cmp("bypass_partial", rd_data_a[31:0], 32'hF034F0BB);
    wr(5'd5, 32'h55555555, 4'hF);
    clear_req = 1'b1;
    step();
    quiet();
    n = 0;
    while (busy_a && n < 40) begin
      n++;
      if (n == 3) begin wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1; wr_be = 4'hF; end
      if (n == 5) begin rd_en_a = 2'b01; rd_addr_a = {5'd0, 5'd5}; end
      if (n == 8) clear_req = 1'b1;
      step();
      quiet();
      if (n == 5) cmp("clr_rd_r5", rd_data_a[31:0], 32'h0);
    end
    cmp("clr_len", 32'(n), 32'd31);
    rd_all(5'd5);
    cmp("r5_cleared", rd_data_a[31:0], 32'h0);
    rd_all(5'd7);
    cmp("r7_dropped", rd_data_a[31:0], 32'h0);
    wr(5'd1, 32'h0000C0DE, 4'hF);
    rd_all(5'd1);
    cmp("pre_rst_val", rd_data_b[127:96], 32'h0000C0DE);
    clear_req = 1'b1;
    step();
    quiet();
    repeat (10) step();
    cmp("mid_clr_hold", rd_data_b[127:96], 32'h0000C0DE);
    rst = 1'b1;
    step();
    rst = 1'b0;
    cmp("rst_mid_rd_b3", rd_data_b[127:96], 32'h0);
    cmp("rst_mid_rd_a0", rd_data_a[31:0], 32'h0);
    count_busy();
    wr(5'd1, 32'hF0F0F0F0, 4'hF);
    rd_all(5'd1);
    for (int k = 0; k < 4; k++) cmp($sformatf("four_port_%0d", k), rd_data_b[k*32 +: 32], 32'hF0F0F0F0);
    cmp("two_port_1", rd_data_a[63:32], 32'hF0F0F0F0);
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
